// File: rtl/dlf_pi_rw_if.sv
// Phase-detector / control-word bundle for the PI loop filter.
// The master side is the driver of decisions; the slave side is the filter.
interface dlf_pi_rw_if #(
  parameter int W = 8
);
  logic [1:0]   mode;
  logic         pd_valid;
  logic         lead;
  logic [W-1:0] master_in;
  logic [W-1:0] slave_out;
  logic         out_valid;
  logic         sat;

  modport master (
    output mode, pd_valid, lead, master_in,
    input  slave_out, out_valid, sat
  );

  modport slave (
    input  mode, pd_valid, lead, master_in,
    output slave_out, out_valid, sat
  );
endinterface

// File: rtl/dlf_pi_rw.sv
// PI loop filter for bang-bang phase detectors: random-walk vote pre-filter,
// saturating integrator, one-cycle proportional kick, clamped control word.
module dlf_pi_rw #(
  parameter int W         = 8,
  parameter int RW_LEN    = 8,
  parameter int INT_STEP  = 1,
  parameter int PROP_STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  dlf_pi_rw_if.slave    bus
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_INT    = 2'b01,
    MODE_PI     = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam int RW_W = $clog2(RW_LEN) + 2;  // holds +/-RW_LEN signed
  localparam int IW   = W + 1;               // integrator width
  localparam int XW   = W + 2;               // integrator with step headroom
  localparam int SW   = W + 3;               // output sum width

  localparam logic signed [RW_W-1:0] RW_POS  = RW_W'(RW_LEN);
  localparam logic signed [RW_W-1:0] RW_NEG  = -RW_W'(RW_LEN);
  localparam logic signed [XW-1:0]   INT_HI  = XW'((1 << W) - 1);
  localparam logic signed [XW-1:0]   INT_LO  = -XW'((1 << W) - 1);
  localparam logic signed [XW-1:0]   INT_INC = XW'(INT_STEP);
  localparam logic signed [SW-1:0]   OUT_HI  = SW'((1 << W) - 1);
  localparam logic signed [SW-1:0]   KICK    = SW'(PROP_STEP);

  mode_e mode;
  assign mode = mode_e'(bus.mode);

  logic signed [RW_W-1:0] rw_q, rw_step, rw_next;
  logic signed [IW-1:0]   integ_q, integ_next;
  logic signed [XW-1:0]   integ_sum;
  logic signed [SW-1:0]   prop, sum;
  logic                   active, vote_up, vote_dn;
  logic [W-1:0]           slave_q, slave_next;
  logic                   out_valid_q, sat_q, sat_next;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    active  = (mode == MODE_INT) || (mode == MODE_PI);
    rw_step = bus.lead ? rw_q + RW_W'(1) : rw_q - RW_W'(1);
    vote_up = active && bus.pd_valid && (rw_step == RW_POS);
    vote_dn = active && bus.pd_valid && (rw_step == RW_NEG);

    rw_next = rw_q;
    if (vote_up || vote_dn)            rw_next = '0;
    else if (active && bus.pd_valid)   rw_next = rw_step;

    // Stepping into a rail in the same direction clamps back to the rail.
    integ_sum = XW'(integ_q);
    if (vote_up)      integ_sum = XW'(integ_q) + INT_INC;
    else if (vote_dn) integ_sum = XW'(integ_q) - INT_INC;

    if (integ_sum > INT_HI)      integ_next = IW'(INT_HI);
    else if (integ_sum < INT_LO) integ_next = IW'(INT_LO);
    else                         integ_next = IW'(integ_sum);

    prop = '0;
    if (mode == MODE_PI) begin
      if (vote_up)      prop = KICK;
      else if (vote_dn) prop = -KICK;
    end

    sum      = SW'($signed({1'b0, bus.master_in})) + SW'(integ_next) + prop;
    sat_next = sum[SW-1] || (sum > OUT_HI);

    if (sum[SW-1])          slave_next = '0;
    else if (sum > OUT_HI)  slave_next = '1;
    else                    slave_next = sum[W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q        <= '0;
      integ_q     <= '0;
      slave_q     <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      unique case (mode)
        MODE_BYPASS: begin
          rw_q        <= '0;
          integ_q     <= '0;
          slave_q     <= bus.master_in;
          out_valid_q <= 1'b0;
          sat_q       <= 1'b0;
        end
        MODE_HOLD: begin
          // integrator, output word and sat flag keep their values
          rw_q        <= '0;
          out_valid_q <= 1'b0;
        end
        default: begin
          rw_q        <= rw_next;
          integ_q     <= integ_next;
          slave_q     <= slave_next;
          out_valid_q <= vote_up || vote_dn;
          sat_q       <= sat_next;
        end
      endcase
    end
  end

  assign bus.slave_out = slave_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_dlf_pi_rw.sv
// Scoreboard bench for dlf_pi_rw: a cycle model predicts each edge's outputs,
// plus direct checks of the headline values from each scenario.
module tb_dlf_pi_rw;

  localparam int W         = 8;
  localparam int RW_LEN    = 4;
  localparam int INT_STEP  = 1;
  localparam int PROP_STEP = 4;
  localparam int OUT_MAX   = (1 << W) - 1;

  typedef struct {
    int slave;
    int ov;
    int sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dlf_pi_rw_if #(.W(W)) bus ();

  dlf_pi_rw #(
    .W(W), .RW_LEN(RW_LEN), .INT_STEP(INT_STEP), .PROP_STEP(PROP_STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";
  exp_t  sb[$];

  // Reference model state
  int m_rw = 0, m_integ = 0, m_slave = 0, m_ov = 0, m_sat = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s/%s got=%0d expected=%0d at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rw = 0; m_integ = 0; m_slave = 0; m_ov = 0; m_sat = 0;
  endtask

  task automatic model_step(input int md, input int pv, input int ld, input int mi);
    int vote, prop, s;
    vote = 0;
    case (md)
      0: begin
        m_rw = 0; m_integ = 0; m_slave = mi; m_ov = 0; m_sat = 0;
      end
      3: begin
        m_rw = 0; m_ov = 0;
      end
      default: begin
        if (pv != 0) begin
          m_rw += (ld != 0) ? 1 : -1;
          if (m_rw == RW_LEN)       begin vote = 1;  m_rw = 0; end
          else if (m_rw == -RW_LEN) begin vote = -1; m_rw = 0; end
        end
        m_integ += vote * INT_STEP;
        if (m_integ > OUT_MAX)  m_integ = OUT_MAX;
        if (m_integ < -OUT_MAX) m_integ = -OUT_MAX;
        prop    = (md == 2) ? vote * PROP_STEP : 0;
        s       = mi + m_integ + prop;
        m_sat   = (s < 0 || s > OUT_MAX) ? 1 : 0;
        m_slave = (s < 0) ? 0 : (s > OUT_MAX) ? OUT_MAX : s;
        m_ov    = (vote != 0) ? 1 : 0;
      end
    endcase
  endtask

  // Drive one cycle, predict, then compare the DUT after the edge.
  task automatic cyc(input int md, input int pv, input int ld, input int mi);
    exp_t e;
    bus.mode      = 2'(md);
    bus.pd_valid  = 1'(pv);
    bus.lead      = 1'(ld);
    bus.master_in = W'(mi);
    model_step(md, pv, ld, mi);
    e.slave = m_slave; e.ov = m_ov; e.sat = m_sat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("slave_out", int'(bus.slave_out), e.slave);
    check("out_valid", int'(bus.out_valid), e.ov);
    check("sat",       int'(bus.sat),       e.sat);
  endtask

  initial begin
    int ov_seen;
    bus.mode = 2'b01; bus.pd_valid = 1'b0; bus.lead = 1'b0; bus.master_in = 8'd150;
    #2;
    check("rst_slave", int'(bus.slave_out), 0);
    check("rst_ov",    int'(bus.out_valid), 0);
    check("rst_sat",   int'(bus.sat),       0);
    #10 rst = 1'b0;   // released between edges

    // 1: four leads in integral-only mode produce one up vote
    phase = "t1_int_up";
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 150);
    check("slave_pre_vote", int'(bus.slave_out), 150);
    cyc(1, 1, 1, 150);
    check("slave_vote", int'(bus.slave_out), 151);
    check("ov_vote",    int'(bus.out_valid), 1);
    check("sat_vote",   int'(bus.sat),       0);

    // 2: PI mode, four lags give integral -1 plus a one-cycle kick of -4
    phase = "t2_pi_kick";
    cyc(0, 0, 0, 96);
    for (int i = 0; i < 4; i++) cyc(2, 1, 0, 96);
    check("slave_kick", int'(bus.slave_out), 91);
    check("ov_kick",    int'(bus.out_valid), 1);
    cyc(2, 0, 0, 96);
    check("slave_settle", int'(bus.slave_out), 95);
    check("ov_settle",    int'(bus.out_valid), 0);

    // 3: alternating decisions never reach a vote
    phase = "t3_alternate";
    cyc(0, 0, 0, 15);
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, (i % 2 == 0) ? 1 : 0, 15);
      ov_seen |= int'(bus.out_valid);
    end
    check("no_vote", ov_seen, 0);
    check("slave_flat", int'(bus.slave_out), 15);

    // 4: upper clamp, then release when master_in drops
    phase = "t4_clamp";
    cyc(0, 0, 0, 250);
    for (int i = 1; i <= 40; i++) begin
      cyc(1, 1, 1, 250);
      if (i == 20) check("sat_at_vote5", int'(bus.sat), 0);
      if (i == 24) check("sat_at_vote6", int'(bus.sat), 1);
    end
    check("slave_clamped", int'(bus.slave_out), 255);
    cyc(1, 0, 0, 0);
    check("slave_unclamp", int'(bus.slave_out), 10);
    check("sat_unclamp",   int'(bus.sat),       0);

    // 5: hold freezes output and discards rw progress
    phase = "t5_hold";
    cyc(0, 0, 0, 171);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 171);
    check("slave_integ3", int'(bus.slave_out), 174);
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(3, 1, 1, 50);
      ov_seen |= int'(bus.out_valid);
    end
    check("hold_no_vote", ov_seen, 0);
    check("hold_slave",   int'(bus.slave_out), 174);
    cyc(1, 0, 0, 50);
    check("resume_slave", int'(bus.slave_out), 53);
    ov_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 50);
      ov_seen |= int'(bus.out_valid);
    end
    check("resume_no_vote", ov_seen, 0);

    // 6: asynchronous reset mid-count clears rw and integ
    phase = "t6_async_rst";
    cyc(0, 0, 0, 100);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 100);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_slave", int'(bus.slave_out), 0);
    check("rst_ov",    int'(bus.out_valid), 0);
    check("rst_sat",   int'(bus.sat),       0);
    #2 rst = 1'b0;
    cyc(1, 1, 1, 100);
    check("post_rst_no_vote", int'(bus.out_valid), 0);
    check("post_rst_slave",   int'(bus.slave_out), 100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dlf_pi_rw.md
# dlf_pi_rw

Parametrised proportional-integral digital loop filter for bang-bang (lead/lag) phase detectors in the CDR/ADPLL path. It pre-filters the binary `lead` decisions with a random-walk vote counter and accumulates votes in a saturating integrator. It adds an optional one-cycle proportional kick and offsets the nominal control word `master_in` to produce the registered, clamped oscillator control word `slave_out`. Run modes are bypass, integral-only, PI and hold.

## Interface
- `W`, 8: control word width (`master_in`, `slave_out`), 4..16.
- `RW_LEN`, 8: random-walk threshold in net votes, 2..128.
- `INT_STEP`, 1: integrator increment per vote, 1..2^(W-2).
- `PROP_STEP`, 4: proportional kick magnitude, 0..2^(W-1).

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  2  00 bypass, 01 integral-only, 10 PI, 11 hold.
- `pd_valid`  in  1  `lead` is valid this cycle.
- `lead`  in  1  1 = lead (step up), 0 = lag (step down); ignored unless `pd_valid`.
- `master_in`  in  W  nominal control word, unsigned.
- `slave_out`  out  W  filtered control word, unsigned, registered.
- `out_valid`  out  1  one-cycle pulse; a vote was applied at this edge.
- `sat`  out  1  high while `slave_out` is clamped at 0 or 2^W-1.

## Operation
- State:
  - `rw`, signed counter, range -(RW_LEN-1)..RW_LEN-1.
  - `integ`, signed W+1 bits, saturating to -(2^W-1)..2^W-1.
  - Output registers.
- Random walk, modes 01/10, on `pd_valid`: `rw_next = rw ± 1`.
  - Reaching +RW_LEN: up vote, `rw` ← 0.
  - Reaching -RW_LEN: down vote, `rw` ← 0.
  - Without `pd_valid`, `rw` is unchanged.
- Integrator, on a vote: `integ` ← sat(`integ` ± INT_STEP).
  - At a rail with a vote in the same direction, `integ` is unchanged.
  - The vote still pulses `out_valid`.
- Proportional term:
  - +PROP_STEP / -PROP_STEP only in mode 10, only at the edge the vote is applied.
  - 0 otherwise.
- Output: `sum = master_in + integ_next + prop`, computed in W+3 signed bits.
  - `slave_out` ← clamp(sum, 0, 2^W-1).
  - `sat` ← (sum < 0) or (sum > 2^W-1).
- Mode 00 bypass:
  - `slave_out` ← `master_in`.
  - `rw` and `integ` cleared.
  - `out_valid` = 0, `sat` = 0.
- Mode 11 hold:
  - `rw` cleared; `integ`, `slave_out` and `sat` frozen.
  - `pd_valid` and `master_in` ignored; `out_valid` = 0.
- Mode changes take effect at the first edge the new value is sampled. No state is flushed except as listed above. Leaving hold resumes with the preserved `integ` and `rw` = 0.

## Timing
- Reset (async, while `rst` = 1): `slave_out` = 0, `out_valid` = 0, `sat` = 0, `rw` = 0, `integ` = 0.
- First active edge after `rst` deasserts applies the normal rules.
- Latency:
  - The `pd_valid` sample that completes a vote updates `integ`, `slave_out` and `out_valid` at that same edge; the new value is visible in the next cycle.
  - A `master_in` change is visible 1 cycle later (modes 00/01/10).
- The proportional kick lasts exactly one cycle; `slave_out` settles to `master_in + integ` at the next edge.
- At most one vote per cycle; no back-pressure; `pd_valid` may be high every cycle.
- Reset mid-count discards `rw` and `integ`; no vote is emitted.

## Test plan
Configuration for all scenarios: W=8, RW_LEN=4, INT_STEP=1, PROP_STEP=4.
1. Reset, then mode 01, `master_in` = 150, 4 consecutive `pd_valid` leads.
   - Required: `slave_out` = 150 after cycles 1-3.
   - Required: 151 with `out_valid` pulse after the 4th sample; `sat` = 0.
2. Mode 10, `master_in` = 96, `integ` = 0, 4 lags.
   - Required: `slave_out` = 91 with `out_valid` for one cycle, then 95.
3. Mode 01, alternating lead/lag for 40 cycles, `master_in` = 15.
   - Required: no `out_valid`; `slave_out` = 15 throughout.
4. Mode 01, `master_in` = 250, 40 leads (10 votes).
   - Required: `slave_out` = 255, `sat` = 1 from the 6th vote on.
   - Then `master_in` = 0: `slave_out` = 10, `sat` = 0 one cycle later.
5. Mode 01, `integ` = 3; switch to mode 11, change `master_in` 171→50, apply 8 leads.
   - Required: `slave_out` stays 174, no `out_valid`.
   - Back to mode 01 with `master_in` = 50: `slave_out` = 53; 3 leads give no vote (`rw` restarted).
6. Mode 01, 3 leads, assert `rst` between clock edges, release, then 1 lead.
   - Required: outputs 0 immediately on `rst`; no vote after the single lead (`rw` was cleared).
